// File: rtl/rob_buffer.sv
// Reorder buffer: in-order allocation at the tail, out-of-order completion by index,
// and in-order retirement of the head through a valid/ready commit handshake.
package rob_pkg;
    localparam int ROB_ENTRIES = 128;
endpackage

package reg_pkg;
    localparam int ADDR_BITS     = 32;
    localparam int NUM_PHYS_REGS = 128;
endpackage

module rob_buffer #(
    parameter  int ROB_ENTRIES = rob_pkg::ROB_ENTRIES,
    parameter  int ADDR_BITS   = reg_pkg::ADDR_BITS,
    parameter  int PHYS_BITS   = $clog2(reg_pkg::NUM_PHYS_REGS),
    localparam int IDX_BITS    = $clog2(ROB_ENTRIES)
) (
    input  logic                 clk_in,
    input  logic                 rst_N_in,
    input  logic                 alloc_valid_in,
    output logic                 alloc_ready_out,
    input  logic [ADDR_BITS-1:0] alloc_pc_in,
    input  logic [PHYS_BITS-1:0] alloc_dest_phys_in,
    output logic [IDX_BITS-1:0]  alloc_ptr_out,
    input  logic                 wb_valid_in,
    input  logic [IDX_BITS-1:0]  wb_ptr_in,
    input  logic                 wb_exception_in,
    output logic                 commit_valid_out,
    input  logic                 commit_ready_in,
    output logic [IDX_BITS-1:0]  commit_ptr_out,
    output logic [ADDR_BITS-1:0] commit_pc_out,
    output logic [PHYS_BITS-1:0] commit_dest_phys_out,
    output logic                 commit_exception_out,
    input  logic                 flush_in,
    output logic [IDX_BITS:0]    count_out
);

    localparam logic [IDX_BITS:0] FULL_COUNT = (IDX_BITS+1)'(ROB_ENTRIES);

    logic [ROB_ENTRIES-1:0] r_valid;
    logic [ROB_ENTRIES-1:0] r_done;
    logic [ROB_ENTRIES-1:0] r_exc;
    logic [ADDR_BITS-1:0]   r_pc   [ROB_ENTRIES];
    logic [PHYS_BITS-1:0]   r_dest [ROB_ENTRIES];
    logic [IDX_BITS-1:0]    r_head;
    logic [IDX_BITS-1:0]    r_tail;
    logic [IDX_BITS:0]      r_count;

    logic                   w_alloc_fire;
    logic                   w_commit_fire;
    logic [IDX_BITS:0]      w_count_nxt;

    // Full test looks only at the registered count; a same-cycle commit does not free a slot.
    assign alloc_ready_out      = (r_count != FULL_COUNT);
    assign alloc_ptr_out        = r_tail;
    assign count_out            = r_count;

    assign commit_valid_out     = r_valid[r_head] && r_done[r_head];
    assign commit_ptr_out       = r_head;
    assign commit_pc_out        = r_pc[r_head];
    assign commit_dest_phys_out = r_dest[r_head];
    assign commit_exception_out = r_exc[r_head];

    assign w_alloc_fire  = alloc_valid_in && alloc_ready_out && !flush_in;
    assign w_commit_fire = commit_valid_out && commit_ready_in && !flush_in;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_alloc_fire, w_commit_fire})
            2'b10:   w_count_nxt = r_count + (IDX_BITS+1)'(1);
            2'b01:   w_count_nxt = r_count - (IDX_BITS+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_exc   <= '0;
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                r_pc[i]   <= '0;
                r_dest[i] <= '0;
            end
        end else if (flush_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_exc   <= '0;
        end else begin
            // Exception is sticky across repeated writebacks to the same entry.
            if (wb_valid_in && r_valid[wb_ptr_in]) begin
                r_done[wb_ptr_in] <= 1'b1;
                r_exc[wb_ptr_in]  <= r_exc[wb_ptr_in] | wb_exception_in;
            end
            if (w_commit_fire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + IDX_BITS'(1);
            end
            if (w_alloc_fire) begin
                r_pc[r_tail]    <= alloc_pc_in;
                r_dest[r_tail]  <= alloc_dest_phys_in;
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_exc[r_tail]   <= 1'b0;
                r_tail          <= r_tail + IDX_BITS'(1);
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_rob_buffer.sv
// Bench for rob_buffer: a queue-based reference model checked every cycle,
// plus directed sequences for full, out-of-order completion, wrap, exception and flush.
module tb_rob_buffer;

    logic        clk_in = 1'b0;
    logic        rst_N_in;
    logic        alloc_valid_in;
    logic        alloc_ready_out;
    logic [31:0] alloc_pc_in;
    logic [6:0]  alloc_dest_phys_in;
    logic [6:0]  alloc_ptr_out;
    logic        wb_valid_in;
    logic [6:0]  wb_ptr_in;
    logic        wb_exception_in;
    logic        commit_valid_out;
    logic        commit_ready_in;
    logic [6:0]  commit_ptr_out;
    logic [31:0] commit_pc_out;
    logic [6:0]  commit_dest_phys_out;
    logic        commit_exception_out;
    logic        flush_in;
    logic [7:0]  count_out;

    rob_buffer dut (
        .clk_in               (clk_in),
        .rst_N_in             (rst_N_in),
        .alloc_valid_in       (alloc_valid_in),
        .alloc_ready_out      (alloc_ready_out),
        .alloc_pc_in          (alloc_pc_in),
        .alloc_dest_phys_in   (alloc_dest_phys_in),
        .alloc_ptr_out        (alloc_ptr_out),
        .wb_valid_in          (wb_valid_in),
        .wb_ptr_in            (wb_ptr_in),
        .wb_exception_in      (wb_exception_in),
        .commit_valid_out     (commit_valid_out),
        .commit_ready_in      (commit_ready_in),
        .commit_ptr_out       (commit_ptr_out),
        .commit_pc_out        (commit_pc_out),
        .commit_dest_phys_out (commit_dest_phys_out),
        .commit_exception_out (commit_exception_out),
        .flush_in             (flush_in),
        .count_out            (count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Reference model: queue of live entries in age order plus per-index done/exception.
    typedef struct {
        logic [31:0] pc;
        logic [6:0]  dest;
        logic [6:0]  ptr;
    } ent_t;

    ent_t         q[$];
    logic [127:0] m_valid;
    logic [127:0] m_done;
    logic [127:0] m_exc;
    logic [6:0]   m_tail;
    int           mon_sz;
    logic         mon_cv;
    logic         mon_rdy;
    ent_t         mon_e;

    always @(negedge clk_in) begin
        if (!rst_N_in) begin
            q.delete();
            m_valid = '0;
            m_done  = '0;
            m_exc   = '0;
            m_tail  = '0;
        end else begin
            mon_sz  = q.size();
            mon_rdy = (mon_sz != 128);
            mon_cv  = (mon_sz > 0) && m_done[q[0].ptr];
            check_val("mon_alloc_ready", alloc_ready_out, mon_rdy);
            check_val("mon_alloc_ptr", alloc_ptr_out, m_tail);
            check_val("mon_count", count_out, mon_sz);
            check_val("mon_commit_valid", commit_valid_out, mon_cv);
            if (mon_cv) begin
                check_val("mon_commit_ptr", commit_ptr_out, q[0].ptr);
                check_val("mon_commit_pc", commit_pc_out, q[0].pc);
                check_val("mon_commit_dest", commit_dest_phys_out, q[0].dest);
                check_val("mon_commit_exc", commit_exception_out, m_exc[q[0].ptr]);
            end
            if (flush_in) begin
                q.delete();
                m_valid = '0;
                m_done  = '0;
                m_exc   = '0;
                m_tail  = '0;
            end else begin
                if (wb_valid_in && m_valid[wb_ptr_in]) begin
                    m_done[wb_ptr_in] = 1'b1;
                    m_exc[wb_ptr_in]  = m_exc[wb_ptr_in] | wb_exception_in;
                end
                if (mon_cv && commit_ready_in) begin
                    mon_e = q.pop_front();
                    m_valid[mon_e.ptr] = 1'b0;
                end
                if (alloc_valid_in && mon_rdy) begin
                    q.push_back('{pc: alloc_pc_in, dest: alloc_dest_phys_in, ptr: m_tail});
                    m_valid[m_tail] = 1'b1;
                    m_done[m_tail]  = 1'b0;
                    m_exc[m_tail]   = 1'b0;
                    m_tail          = m_tail + 7'd1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_N_in           = 1'b0;
        alloc_valid_in     = 1'b0;
        alloc_pc_in        = '0;
        alloc_dest_phys_in = '0;
        wb_valid_in        = 1'b0;
        wb_ptr_in          = '0;
        wb_exception_in    = 1'b0;
        commit_ready_in    = 1'b0;
        flush_in           = 1'b0;
        repeat (3) cyc();

        check_val("rst_alloc_ready", alloc_ready_out, 1);
        check_val("rst_alloc_ptr", alloc_ptr_out, 0);
        check_val("rst_commit_valid", commit_valid_out, 0);
        check_val("rst_commit_ptr", commit_ptr_out, 0);
        check_val("rst_count", count_out, 0);
        check_val("rst_commit_pc", commit_pc_out, 0);
        check_val("rst_commit_dest", commit_dest_phys_out, 0);
        check_val("rst_commit_exc", commit_exception_out, 0);
        rst_N_in = 1'b1;
        cyc();

        // Fill all 128 entries, then a 129th request must be refused.
        for (int i = 0; i < 128; i++) begin
            alloc_valid_in     = 1'b1;
            alloc_pc_in        = 32'h1000 + 32'(i * 4);
            alloc_dest_phys_in = 7'(i);
            check_val("fill_alloc_ptr", alloc_ptr_out, i);
            cyc();
        end
        alloc_pc_in = 32'hDEAD0000;
        check_val("full_count", count_out, 128);
        check_val("full_ready", alloc_ready_out, 0);
        cyc();
        check_val("full_hold_count", count_out, 128);
        alloc_valid_in = 1'b0;

        // Full with done head: commit and alloc together -> only the commit fires.
        wb_valid_in = 1'b1;
        wb_ptr_in   = 7'd0;
        cyc();
        wb_valid_in = 1'b0;
        check_val("full_head_valid", commit_valid_out, 1);
        check_val("full_head_pc", commit_pc_out, 32'h1000);
        commit_ready_in = 1'b1;
        alloc_valid_in  = 1'b1;
        alloc_pc_in     = 32'hBAD0;
        check_val("full_same_cycle_ready", alloc_ready_out, 0);
        cyc();
        commit_ready_in = 1'b0;
        alloc_valid_in  = 1'b0;
        check_val("after_commit_ready", alloc_ready_out, 1);
        check_val("after_commit_count", count_out, 127);
        flush_in = 1'b1;
        cyc();
        flush_in = 1'b0;
        check_val("flush1_count", count_out, 0);

        // Out-of-order completion: commits wait for index 0, then drain back to back.
        for (int i = 0; i < 4; i++) begin
            alloc_valid_in     = 1'b1;
            alloc_pc_in        = 32'h100 + 32'(i * 4);
            alloc_dest_phys_in = 7'(10 + i);
            cyc();
        end
        alloc_valid_in  = 1'b0;
        commit_ready_in = 1'b1;
        wb_valid_in     = 1'b1;
        wb_ptr_in = 7'd3; cyc(); check_val("ooo_wait_3", commit_valid_out, 0);
        wb_ptr_in = 7'd1; cyc(); check_val("ooo_wait_1", commit_valid_out, 0);
        wb_ptr_in = 7'd2; cyc(); check_val("ooo_wait_2", commit_valid_out, 0);
        wb_ptr_in = 7'd0; cyc();
        wb_valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_val("ooo_commit_valid", commit_valid_out, 1);
            check_val("ooo_commit_pc", commit_pc_out, 32'h100 + 32'(k * 4));
            cyc();
        end
        commit_ready_in = 1'b0;
        check_val("ooo_drained", count_out, 0);

        // Sticky exception and writeback to an unallocated index.
        flush_in = 1'b1; cyc(); flush_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alloc_valid_in     = 1'b1;
            alloc_pc_in        = 32'h300 + 32'(i * 4);
            alloc_dest_phys_in = 7'(20 + i);
            cyc();
        end
        alloc_valid_in  = 1'b0;
        wb_valid_in     = 1'b1;
        wb_ptr_in = 7'd2; wb_exception_in = 1'b1; cyc();
        wb_ptr_in = 7'd2; wb_exception_in = 1'b0; cyc();
        wb_ptr_in = 7'd5; wb_exception_in = 1'b1; cyc();
        wb_exception_in = 1'b0;
        check_val("exc_stray_count", count_out, 3);
        check_val("exc_head_not_done", commit_valid_out, 0);
        wb_ptr_in = 7'd0; cyc();
        wb_ptr_in = 7'd1; cyc();
        wb_valid_in = 1'b0;
        check_val("exc_head_ready", commit_valid_out, 1);
        commit_ready_in = 1'b1;
        check_val("exc_e0", commit_exception_out, 0);
        cyc();
        check_val("exc_e1", commit_exception_out, 0);
        cyc();
        check_val("exc_e2_ptr", commit_ptr_out, 2);
        check_val("exc_e2", commit_exception_out, 1);
        cyc();
        commit_ready_in = 1'b0;
        check_val("exc_drained", count_out, 0);

        // Steady state: one alloc, one writeback, one commit per cycle across pointer wrap.
        flush_in = 1'b1; cyc(); flush_in = 1'b0;
        commit_ready_in = 1'b1;
        for (int c = 0; c < 300; c++) begin
            alloc_valid_in     = 1'b1;
            alloc_pc_in        = 32'h2000 + 32'(c * 4);
            alloc_dest_phys_in = 7'(c);
            wb_valid_in        = (c >= 3);
            wb_ptr_in          = 7'(c - 3);
            if (c >= 4) check_val("steady_count", count_out, 4);
            cyc();
        end
        alloc_valid_in = 1'b0;
        for (int c = 300; c < 303; c++) begin
            wb_valid_in = 1'b1;
            wb_ptr_in   = 7'(c - 3);
            cyc();
        end
        wb_valid_in = 1'b0;
        repeat (3) cyc();
        check_val("steady_drained", count_out, 0);
        check_val("steady_tail_wrap", alloc_ptr_out, 300 % 128);
        commit_ready_in = 1'b0;

        // Flush with alloc and commit both requested in the same cycle.
        for (int i = 0; i < 10; i++) begin
            alloc_valid_in     = 1'b1;
            alloc_pc_in        = 32'h5000 + 32'(i * 4);
            alloc_dest_phys_in = 7'(40 + i);
            cyc();
        end
        alloc_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_valid_in = 1'b1;
            wb_ptr_in   = 7'(44 + i);
            cyc();
        end
        wb_valid_in = 1'b0;
        check_val("flush_pre_count", count_out, 10);
        check_val("flush_pre_cv", commit_valid_out, 1);
        flush_in        = 1'b1;
        alloc_valid_in  = 1'b1;
        alloc_pc_in     = 32'hF00D;
        commit_ready_in = 1'b1;
        cyc();
        flush_in        = 1'b0;
        alloc_valid_in  = 1'b0;
        commit_ready_in = 1'b0;
        check_val("flush_count", count_out, 0);
        check_val("flush_cv", commit_valid_out, 0);
        check_val("flush_alloc_ptr", alloc_ptr_out, 0);
        check_val("flush_ready", alloc_ready_out, 1);

        alloc_valid_in     = 1'b1;
        alloc_pc_in        = 32'h600;
        alloc_dest_phys_in = 7'd77;
        cyc();
        alloc_valid_in = 1'b0;
        wb_valid_in    = 1'b1;
        wb_ptr_in      = 7'd0;
        cyc();
        wb_valid_in     = 1'b0;
        commit_ready_in = 1'b1;
        check_val("postflush_ptr", commit_ptr_out, 0);
        check_val("postflush_pc", commit_pc_out, 32'h600);
        cyc();
        commit_ready_in = 1'b0;

        // Asynchronous reset in the middle of a cycle clears state without a clock edge.
        for (int i = 0; i < 2; i++) begin
            alloc_valid_in = 1'b1;
            alloc_pc_in    = 32'h700 + 32'(i * 4);
            cyc();
        end
        alloc_valid_in = 1'b0;
        #2;
        rst_N_in = 1'b0;
        #1;
        check_val("arst_count", count_out, 0);
        check_val("arst_alloc_ptr", alloc_ptr_out, 0);
        check_val("arst_commit_pc", commit_pc_out, 0);
        check_val("arst_ready", alloc_ready_out, 1);
        cyc();
        rst_N_in = 1'b1;
        cyc();
        check_val("arst_release_count", count_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rob_buffer.md
# rob_buffer

In-order reorder buffer storage and retire engine for the out-of-order backend. It sits between rename/dispatch, which allocates entries at the tail, and the execute/writeback units, which mark entries done by ROB index. It presents the oldest entry to the commit stage through a valid/ready handshake. Sizing and pointer widths follow `rob_pkg::ROB_ENTRIES`.

## Interface
Parameters:
- `ROB_ENTRIES`, default `rob_pkg::ROB_ENTRIES` (128): number of entries; must be a power of two.
- `ADDR_BITS`, default `reg_pkg::ADDR_BITS`: PC width.
- `PHYS_BITS`, default `$clog2(reg_pkg::NUM_PHYS_REGS)`: physical register index width.
- `IDX_BITS` (derived), `$clog2(ROB_ENTRIES)`.

Ports:
- `clk_in  in  1`: single clock; all state updates on its rising edge.
- `rst_N_in  in  1`: asynchronous, active-low reset.
- `alloc_valid_in  in  1`: dispatch requests one entry.
- `alloc_ready_out  out  1`: buffer can accept an allocation.
- `alloc_pc_in  in  ADDR_BITS`: PC of the allocating uop.
- `alloc_dest_phys_in  in  PHYS_BITS`: destination physical register.
- `alloc_ptr_out  out  IDX_BITS`: index the allocation receives (current tail).
- `wb_valid_in  in  1`: writeback marks one entry done.
- `wb_ptr_in  in  IDX_BITS`: entry being completed.
- `wb_exception_in  in  1`: completing uop raised an exception.
- `commit_valid_out  out  1`: head entry is valid and done.
- `commit_ready_in  in  1`: commit stage accepts the head.
- `commit_ptr_out  out  IDX_BITS`: head index.
- `commit_pc_out  out  ADDR_BITS`: head PC.
- `commit_dest_phys_out  out  PHYS_BITS`: head destination register.
- `commit_exception_out  out  1`: head completed with an exception.
- `flush_in  in  1`: discard all entries.
- `count_out  out  IDX_BITS+1`: occupied entries.

## Operation
- Per-entry state: `valid`, `done`, `exception`, `pc`, `dest_phys`. Head and tail pointers are `IDX_BITS` wide and wrap modulo `ROB_ENTRIES` with no special case. The count is `IDX_BITS+1` wide.
- Allocate when `alloc_valid_in && alloc_ready_out`:
  - write pc/dest into `entry[tail]`;
  - set `valid=1`, `done=0`, `exception=0`;
  - `tail++`.
- `alloc_ready_out = (count != ROB_ENTRIES)`. It uses the registered count only. There is no bypass from a same-cycle commit, so when full, allocation stays blocked for that cycle even if a commit occurs.
- Writeback when `wb_valid_in`:
  - if `entry[wb_ptr_in].valid`, set `done=1` and `exception |= wb_exception_in` (exception is sticky);
  - a writeback to an invalid entry is ignored;
  - a repeat writeback to a done entry is legal and idempotent apart from the exception OR.
- Commit:
  - `commit_valid_out = entry[head].valid && entry[head].done`;
  - `commit_*` outputs are driven combinationally from `entry[head]`;
  - on `commit_valid_out && commit_ready_in`: clear `entry[head].valid`, `head++`.
- Exceptions are not acted on here. An excepting head commits like any other entry, and the commit stage is responsible for asserting `flush_in`.
- Count update: `count + alloc_fire - commit_fire`. Simultaneous alloc and commit leaves count unchanged.
- Flush has priority over alloc, writeback and commit in the same cycle. It clears all `valid`/`done`/`exception` bits and sets `head=tail=count=0`.

## Timing
- Reset (asynchronous, while `rst_N_in=0`):
  - head=0, tail=0, count=0, all valid/done/exception bits = 0;
  - outputs: `alloc_ready_out=1`, `alloc_ptr_out=0`, `commit_valid_out=0`, `commit_ptr_out=0`, `count_out=0`;
  - `commit_pc_out`/`commit_dest_phys_out`/`commit_exception_out` = 0, since the entry payload registers also reset to 0.
- Reset mid-operation discards all contents immediately.
- Allocation latency: an allocation at cycle N makes the entry valid from N+1. A writeback for it is accepted from N+1 onward.
- Writeback to commit: writeback at cycle M raises `commit_valid_out` at M+1 if that entry is the head. Minimum alloc-to-commit is 2 cycles.
- Throughput: one alloc, one writeback and one commit per cycle.
- Writeback to the head in the same cycle it is being checked does not commit that cycle.
- Flush at cycle F: `commit_valid_out=0`, `count_out=0`, `alloc_ready_out=1` from F+1. An alloc presented at F is dropped.

## Test plan
- Reset, then 128 back-to-back allocs with `commit_ready_in=0` -> `alloc_ptr_out` runs 0..127, `count_out=128`, `alloc_ready_out=0`; a 129th request is not accepted.
- Alloc 4 entries (pc 0x100..0x10C), writeback in order 3,1,2,0 -> no commit until index 0 is done; then 4 commits in consecutive cycles with PCs 0x100, 0x104, 0x108, 0x10C.
- Full buffer with head done, `commit_ready_in=1` and `alloc_valid_in=1` in the same cycle -> commit fires, alloc does not; next cycle `alloc_ready_out=1`, `count_out=127`.
- Steady state of one alloc + one writeback + one commit per cycle for 300 cycles -> pointers wrap past 127 to 0, `count_out` stays constant, commit PCs stay in order.
- Writeback index 2 with `wb_exception_in=1`, then a second writeback to index 2 with exception=0 -> at commit, `commit_exception_out=1`. A writeback to an unallocated index changes nothing.
- 10 entries live with some done, assert `flush_in` together with alloc and commit -> next cycle `count_out=0`, `commit_valid_out=0`, `alloc_ptr_out=0`; no commit fired during the flush cycle.
